// File: rtl/usr_serial_deserializer.sv
// Serial-to-parallel receiver for a universal shift register's serial output.
// Collects WIDTH bits in either bit order, hands each finished word to a
// consumer through a one-word valid/ready holding register, and raises a
// sticky overrun flag whenever a finished word finds the holding register full.
module usr_serial_deserializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sin_i,
    input  logic             sin_valid_i,
    input  logic             msb_first_i,
    input  logic             frame_start_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             overrun_o,
    input  logic             overrun_clr_i
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] sr_base;
    logic [CNT_W-1:0] cnt_base;
    logic             dir_eff;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             hold_free;

    // Next-state: frame_start clears the partial word before the current bit
    // is shifted in, so a coincident bit starts a fresh word.
    always_comb begin
        sr_base      = frame_start_i ? '0 : sr_q;
        cnt_base     = frame_start_i ? '0 : bit_cnt_q;
        // Direction is only taken from msb_first_i on the first bit of a word.
        dir_eff      = (cnt_base == '0) ? msb_first_i : dir_q;
        shifted      = dir_eff ? {sr_base[WIDTH-2:0], sin_i} : {sin_i, sr_base[WIDTH-1:1]};
        complete     = sin_valid_i && (cnt_base == CNT_W'(WIDTH - 1));
        hold_free    = !dout_valid_q || dout_ready_i;

        sr_d         = sr_base;
        bit_cnt_d    = cnt_base;
        dir_d        = dir_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready_i;
        overrun_d    = overrun_clr_i ? 1'b0 : overrun_q;

        if (sin_valid_i) begin
            sr_d  = shifted;
            dir_d = dir_eff;
            if (complete) begin
                bit_cnt_d = '0;
                if (hold_free) begin
                    dout_d       = shifted;
                    dout_valid_d = 1'b1;
                end else begin
                    // Drop wins over a same-cycle clear.
                    overrun_d = 1'b1;
                end
            end else begin
                bit_cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            dir_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            dir_q        <= dir_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign busy_o       = (bit_cnt_q != '0);
    assign bit_cnt_o    = bit_cnt_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_usr_serial_deserializer.sv
// Self-checking bench for usr_serial_deserializer: directed scenarios plus a
// randomized run against a bit-queue reference model.
module tb_usr_serial_deserializer;

    localparam int unsigned W = 8;
    localparam int unsigned CW = 4;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          sin_i = 1'b0;
    logic          sin_valid_i = 1'b0;
    logic          msb_first_i = 1'b0;
    logic          frame_start_i = 1'b0;
    logic [W-1:0]  dout_o;
    logic          dout_valid_o;
    logic          dout_ready_i = 1'b0;
    logic          busy_o;
    logic [CW-1:0] bit_cnt_o;
    logic          overrun_o;
    logic          overrun_clr_i = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model: bits of the current word in arrival order.
    bit           m_bits[$];
    bit           m_dir = 1'b0;
    logic [W-1:0] m_dout = '0;
    bit           m_valid = 1'b0;
    bit           m_ovr = 1'b0;

    always #5 clk_i = ~clk_i;

    usr_serial_deserializer #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .sin_i        (sin_i),
        .sin_valid_i  (sin_valid_i),
        .msb_first_i  (msb_first_i),
        .frame_start_i(frame_start_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .dout_ready_i (dout_ready_i),
        .busy_o       (busy_o),
        .bit_cnt_o    (bit_cnt_o),
        .overrun_o    (overrun_o),
        .overrun_clr_i(overrun_clr_i)
    );

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_update();
        logic [W-1:0] word;
        bit nvalid;
        bit dropped;
        if (reset_i) begin
            m_bits.delete();
            m_dir = 1'b0;
            m_dout = '0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
            return;
        end
        nvalid = m_valid && !dout_ready_i;
        dropped = 1'b0;
        if (frame_start_i) m_bits.delete();
        if (sin_valid_i) begin
            if (m_bits.size() == 0) m_dir = msb_first_i;
            m_bits.push_back(sin_i);
            if (m_bits.size() == W) begin
                word = '0;
                for (int i = 0; i < W; i++) begin
                    if (m_dir) word[W-1-i] = m_bits[i];
                    else word[i] = m_bits[i];
                end
                m_bits.delete();
                if (!m_valid || dout_ready_i) begin
                    m_dout = word;
                    nvalid = 1'b1;
                end else begin
                    dropped = 1'b1;
                end
            end
        end
        if (overrun_clr_i) m_ovr = 1'b0;
        if (dropped) m_ovr = 1'b1;
        m_valid = nvalid;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input bit b);
        sin_i = b;
        sin_valid_i = 1'b1;
        tick();
        sin_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] word, input bit msb);
        for (int i = 0; i < W; i++) send_bit(msb ? word[W-1-i] : word[i]);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sin_valid_i = ~sin_valid_i;
            sin_i = 1'b1;
            tick();
        end
        sin_valid_i = 1'b0;
        checks++;
        if (dout_o !== '0 || dout_valid_o !== 1'b0 || busy_o !== 1'b0 ||
            bit_cnt_o !== '0 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL reset: dout=%h valid=%b busy=%b cnt=%0d ovr=%b, required all 0",
                     dout_o, dout_valid_o, busy_o, bit_cnt_o, overrun_o);
        end
        reset_i = 1'b0;
        tick();
        checks++;
        if (bit_cnt_o !== '0) begin
            failures++;
            $display("FAIL reset_release_cnt: got %0d required 0", bit_cnt_o);
        end
    endtask

    task automatic test_lsb_first();
        bit seq[8] = '{0, 1, 0, 1, 0, 0, 0, 0};
        msb_first_i = 1'b0;
        dout_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(seq[i]);
        checks++;
        if (dout_o !== 8'h0A || dout_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL lsb_first: dout=%h valid=%b required 0a/1", dout_o, dout_valid_o);
        end
        tick();
        checks++;
        if (dout_valid_o !== 1'b0 || dout_o !== 8'h0A) begin
            failures++;
            $display("FAIL lsb_accept: dout=%h valid=%b required 0a/0", dout_o, dout_valid_o);
        end
    endtask

    task automatic test_msb_first();
        bit seq[8] = '{0, 0, 0, 0, 1, 0, 1, 0};
        msb_first_i = 1'b1;
        dout_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(seq[i]);
            if (i == 3) begin
                msb_first_i = 1'b0;
                checks++;
                if (bit_cnt_o !== 4'd4 || busy_o !== 1'b1) begin
                    failures++;
                    $display("FAIL msb_midword: cnt=%0d busy=%b required 4/1", bit_cnt_o, busy_o);
                end
            end
        end
        checks++;
        if (dout_o !== 8'h0A || dout_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL msb_first: dout=%h valid=%b busy=%b required 0a/1/0",
                     dout_o, dout_valid_o, busy_o);
        end
        tick();
    endtask

    task automatic test_overrun();
        dout_ready_i = 1'b0;
        send_word(8'hA5, 1'b1);
        checks++;
        if (dout_o !== 8'hA5 || dout_valid_o !== 1'b1 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL ovr_first: dout=%h valid=%b ovr=%b required a5/1/0",
                     dout_o, dout_valid_o, overrun_o);
        end
        send_word(8'h3C, 1'b1);
        checks++;
        if (dout_o !== 8'hA5 || dout_valid_o !== 1'b1 || overrun_o !== 1'b1) begin
            failures++;
            $display("FAIL ovr_drop: dout=%h valid=%b ovr=%b required a5/1/1",
                     dout_o, dout_valid_o, overrun_o);
        end
        dout_ready_i = 1'b1;
        tick();
        checks++;
        if (dout_valid_o !== 1'b0 || overrun_o !== 1'b1 || dout_o !== 8'hA5) begin
            failures++;
            $display("FAIL ovr_drain: dout=%h valid=%b ovr=%b required a5/0/1",
                     dout_o, dout_valid_o, overrun_o);
        end
        overrun_clr_i = 1'b1;
        tick();
        overrun_clr_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear: got %b required 0", overrun_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1, w2;
        w1 = W'($urandom);
        w2 = W'($urandom);
        msb_first_i = 1'b0;
        dout_ready_i = 1'b0;
        send_word(w1, 1'b0);
        checks++;
        if (dout_o !== w1 || dout_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_word1: dout=%h valid=%b required %h/1", dout_o, dout_valid_o, w1);
        end
        for (int i = 0; i < W; i++) begin
            dout_ready_i = (i == W - 1);
            send_bit(w2[i]);
        end
        checks++;
        if (dout_o !== w2 || dout_valid_o !== 1'b1 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_word2: dout=%h valid=%b ovr=%b required %h/1/0",
                     dout_o, dout_valid_o, overrun_o, w2);
        end
        tick();
        checks++;
        if (dout_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: valid=%b required 0", dout_valid_o);
        end
    endtask

    task automatic test_frame_start();
        bit b[8];
        logic [W-1:0] exp;
        msb_first_i = 1'b0;
        dout_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        checks++;
        if (bit_cnt_o !== 4'd5) begin
            failures++;
            $display("FAIL fs_partial: cnt=%0d required 5", bit_cnt_o);
        end
        for (int i = 0; i < 8; i++) b[i] = 1'($urandom);
        frame_start_i = 1'b1;
        send_bit(b[0]);
        frame_start_i = 1'b0;
        checks++;
        if (bit_cnt_o !== 4'd1) begin
            failures++;
            $display("FAIL fs_restart: cnt=%0d required 1", bit_cnt_o);
        end
        for (int i = 1; i < 8; i++) send_bit(b[i]);
        exp = '0;
        for (int i = 0; i < 8; i++) exp[i] = b[i];
        checks++;
        if (dout_o !== exp || dout_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL fs_word: dout=%h valid=%b required %h/1", dout_o, dout_valid_o, exp);
        end
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        checks++;
        if (bit_cnt_o !== 4'd4) begin
            failures++;
            $display("FAIL fs_prereset: cnt=%0d required 4", bit_cnt_o);
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++;
        if (bit_cnt_o !== '0 || dout_valid_o !== 1'b0 || dout_o !== '0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL fs_reset: cnt=%0d valid=%b dout=%h busy=%b required 0/0/00/0",
                     bit_cnt_o, dout_valid_o, dout_o, busy_o);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 3000; c++) begin
            reset_i = ($urandom_range(0, 199) == 0);
            sin_i = 1'($urandom);
            sin_valid_i = ($urandom_range(0, 3) != 0);
            msb_first_i = 1'($urandom);
            frame_start_i = ($urandom_range(0, 39) == 0);
            dout_ready_i = ($urandom_range(0, 2) == 0);
            overrun_clr_i = ($urandom_range(0, 29) == 0);
            tick();
            checks++;
            if (dout_o !== m_dout || dout_valid_o !== m_valid || overrun_o !== m_ovr ||
                bit_cnt_o !== CW'(m_bits.size()) || busy_o !== (m_bits.size() != 0)) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random cyc %0d: dout=%h v=%b ovr=%b cnt=%0d busy=%b required %h/%b/%b/%0d/%b",
                             c, dout_o, dout_valid_o, overrun_o, bit_cnt_o, busy_o,
                             m_dout, m_valid, m_ovr, m_bits.size(), m_bits.size() != 0);
                bad++;
            end
        end
        reset_i = 1'b0;
        sin_valid_i = 1'b0;
        frame_start_i = 1'b0;
        overrun_clr_i = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_overrun();
        test_back_to_back();
        test_frame_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
